// File: rtl/vsa_mem_unit_pkg.sv
// Shared widths, FSM encoding and debug struct for the VSA memory subsystem.
package vsa_mem_unit_pkg;

  localparam int IW    = 12;
  localparam int DW    = 5;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;
  localparam int CNTW  = 8;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } vsa_state_e;

  typedef struct packed {
    vsa_state_e      state;
    logic [AW-1:0]   ld_addr;
    logic [1:0]      nib_idx;
  } mem_dbg_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] val);
    return (val == '1) ? val : val + CNTW'(1);
  endfunction

endpackage

// File: rtl/vsa_nibble_packer.sv
// Assembles three MSB-first loader nibbles into one 12-bit instruction word.
module vsa_nibble_packer
  import vsa_mem_unit_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          xfer,
  input  logic [3:0]    nibble,
  input  logic          last,
  output logic [IW-1:0] word,
  output logic          word_done,
  output logic          last_misaligned,
  output logic [1:0]    nib_idx
);

  logic [7:0] shift_q;

  // The third nibble is combined combinationally so the word lands in the
  // same cycle as its final transfer.
  assign word            = {shift_q, nibble};
  assign word_done       = xfer && (nib_idx == 2'd2);
  assign last_misaligned = xfer && last && (nib_idx != 2'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      nib_idx <= 2'd0;
      shift_q <= '0;
    end else if (xfer) begin
      shift_q <= {shift_q[3:0], nibble};
      if (nib_idx == 2'd2 || last) nib_idx <= 2'd0;
      else                         nib_idx <= nib_idx + 2'd1;
    end
  end

endmodule

// File: rtl/vsa_mem_unit.sv
// VSA memory subsystem: loader FSM, 32x12 instruction memory, 32x5 data memory.
module vsa_mem_unit
  import vsa_mem_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            ld_valid,
  input  logic [3:0]      ld_nibble,
  input  logic            ld_last,
  output logic            ld_ready,
  output logic            run,
  output logic            load_err,
  input  logic [AW-1:0]   PC,
  output logic [IW-1:0]   instruction,
  input  logic [AW-1:0]   ALUOutput,
  input  logic [DW-1:0]   dataout,
  input  logic            wr,
  output logic [DW-1:0]   datain,
  output logic [CNTW-1:0] st_count,
  output mem_dbg_t        dbg
);

  // Loader handshake: a nibble moves on any posedge where ld_valid and
  // ld_ready are both high; ld_ready depends only on state, never on ld_valid.

  vsa_state_e    state, next_state;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] imem [DEPTH];
  logic [DW-1:0] dmem [DEPTH];

  logic          xfer;
  logic [IW-1:0] word;
  logic          word_done;
  logic          last_misaligned;
  logic [1:0]    nib_idx;
  logic          store;

  assign ld_ready = (state == ST_LOAD);
  assign run      = (state == ST_RUN);
  assign load_err = (state == ST_ERR);
  assign xfer     = ld_valid && ld_ready;
  assign store    = run && wr;

  assign instruction = run ? imem[PC] : '0;
  assign datain      = run ? dmem[ALUOutput] : '0;

  assign dbg = '{state: state, ld_addr: ld_addr, nib_idx: nib_idx};

  vsa_nibble_packer u_packer (
    .clock           (clock),
    .reset           (reset),
    .xfer            (xfer),
    .nibble          (ld_nibble),
    .last            (ld_last),
    .word            (word),
    .word_done       (word_done),
    .last_misaligned (last_misaligned),
    .nib_idx         (nib_idx)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD: begin
        if (last_misaligned)
          next_state = ST_ERR;
        else if (word_done && (ld_last || ld_addr == AW'(DEPTH - 1)))
          next_state = ST_RUN;
      end
      ST_RUN:  next_state = ST_RUN;
      ST_ERR:  next_state = ST_ERR;
      default: next_state = ST_ERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_LOAD;
      ld_addr  <= '0;
      st_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imem[i] <= '0;
        dmem[i] <= '0;
      end
    end else begin
      state <= next_state;
      // word_done only fires in LOAD because xfer is gated by ld_ready.
      if (word_done) begin
        imem[ld_addr] <= word;
        ld_addr       <= ld_addr + AW'(1);
      end
      if (store) begin
        dmem[ALUOutput] <= dataout;
        st_count        <= sat_inc(st_count);
      end
    end
  end

endmodule

// File: tb/tb_vsa_mem_unit.sv
// Directed self-checking bench for vsa_mem_unit: load, error, full, store, saturation, reset.
module tb_vsa_mem_unit;
  import vsa_mem_unit_pkg::*;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            ld_valid = 1'b0;
  logic [3:0]      ld_nibble = '0;
  logic            ld_last = 1'b0;
  logic            ld_ready;
  logic            run;
  logic            load_err;
  logic [AW-1:0]   PC = '0;
  logic [IW-1:0]   instruction;
  logic [AW-1:0]   ALUOutput = '0;
  logic [DW-1:0]   dataout = '0;
  logic            wr = 1'b0;
  logic [DW-1:0]   datain;
  logic [CNTW-1:0] st_count;
  mem_dbg_t        dbg;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vsa_mem_unit dut (
    .clock       (clock),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_nibble   (ld_nibble),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .run         (run),
    .load_err    (load_err),
    .PC          (PC),
    .instruction (instruction),
    .ALUOutput   (ALUOutput),
    .dataout     (dataout),
    .wr          (wr),
    .datain      (datain),
    .st_count    (st_count),
    .dbg         (dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; wr = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send(input logic [3:0] nib, input logic last);
    @(negedge clock);
    ld_valid = 1'b1; ld_nibble = nib; ld_last = last;
    @(negedge clock);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic read_imem(input string tag, input logic [AW-1:0] addr, input logic [IW-1:0] exp);
    PC = addr;
    #1;
    check(tag, 32'(instruction), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    check("rst_run", 32'(run), 0);
    check("rst_err", 32'(load_err), 0);
    check("rst_ready", 32'(ld_ready), 1);
    check("rst_count", 32'(st_count), 0);
    check("rst_instr", 32'(instruction), 0);
    check("rst_datain", 32'(datain), 0);
    check("rst_state", 32'(dbg.state), 32'(ST_LOAD));

    // T1: two-word program
    send(4'h6, 1'b0); send(4'h0, 1'b0); send(4'h3, 1'b0);
    check("t1_mid_run", 32'(run), 0);
    check("t1_mid_addr", 32'(dbg.ld_addr), 1);
    send(4'h8, 1'b0); send(4'h8, 1'b0); send(4'h1, 1'b1);
    check("t1_run", 32'(run), 1);
    check("t1_ready", 32'(ld_ready), 0);
    read_imem("t1_imem0", 5'd0, 12'h603);
    read_imem("t1_imem1", 5'd1, 12'h881);
    read_imem("t1_imem2", 5'd2, 12'h000);

    // T2: ld_last on the second nibble of a word
    do_reset();
    send(4'h1, 1'b0); send(4'h2, 1'b1);
    check("t2_err", 32'(load_err), 1);
    check("t2_run", 32'(run), 0);
    check("t2_ready", 32'(ld_ready), 0);
    PC = 5'd0; #1;
    check("t2_instr", 32'(instruction), 0);
    send(4'h5, 1'b0); send(4'h5, 1'b0); send(4'h5, 1'b1);
    @(negedge clock); wr = 1'b1; @(negedge clock); wr = 1'b0;
    check("t2_sticky", 32'(dbg.state), 32'(ST_ERR));
    check("t2_count", 32'(st_count), 0);

    // T3: fill all 32 words without ld_last
    do_reset();
    for (int w = 0; w < DEPTH; w++) begin
      logic [7:0] w3;
      w3 = 8'(w * 3);
      send(4'(w), 1'b0); send(4'hA, 1'b0); send(w3[3:0], 1'b0);
      if (w == 30) begin
        check("t3_w30_state", 32'(dbg.state), 32'(ST_LOAD));
        check("t3_w30_ready", 32'(ld_ready), 1);
      end
    end
    check("t3_run", 32'(run), 1);
    check("t3_ready", 32'(ld_ready), 0);
    send(4'hF, 1'b1);
    check("t3_97th_state", 32'(dbg.state), 32'(ST_RUN));
    read_imem("t3_imem0", 5'd0, 12'h0A0);
    read_imem("t3_imem17", 5'd17, 12'h1A3);
    read_imem("t3_imem31", 5'd31, 12'hFAD);

    // T4: store then load, same-cycle read sees old value
    @(negedge clock);
    wr = 1'b1; ALUOutput = 5'd9; dataout = 5'h15;
    #1;
    check("t4_same_cycle", 32'(datain), 0);
    @(negedge clock);
    wr = 1'b0;
    #1;
    check("t4_datain", 32'(datain), 32'h15);
    check("t4_count", 32'(st_count), 1);
    ALUOutput = 5'd10; #1;
    check("t4_other_addr", 32'(datain), 0);

    // T5: saturation at 255 over 300 total stores
    for (int i = 1; i < 300; i++) begin
      @(negedge clock);
      if (i == 254) check("t5_count254", 32'(st_count), 32'hFE);
      wr = 1'b1; ALUOutput = 5'd3; dataout = 5'(i);
    end
    @(negedge clock);
    wr = 1'b0;
    #1;
    check("t5_sat", 32'(st_count), 32'hFF);
    check("t5_last_data", 32'(datain), 32'd11);
    ALUOutput = 5'd9; #1;
    check("t5_addr9", 32'(datain), 32'h15);

    // T5 gating: stores during LOAD are dropped
    do_reset();
    @(negedge clock);
    wr = 1'b1; ALUOutput = 5'd9; dataout = 5'h07;
    @(negedge clock);
    wr = 1'b0;
    check("t5_gate_count", 32'(st_count), 0);
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b1);
    check("t5_gate_run", 32'(run), 1);
    ALUOutput = 5'd9; #1;
    check("t5_gate_dmem", 32'(datain), 0);
    check("t5_gate_count2", 32'(st_count), 0);

    // T6: reset in the middle of the second word
    do_reset();
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    check("t6_pre_addr", 32'(dbg.ld_addr), 1);
    check("t6_pre_idx", 32'(dbg.nib_idx), 1);
    do_reset();
    #1;
    check("t6_addr", 32'(dbg.ld_addr), 0);
    check("t6_idx", 32'(dbg.nib_idx), 0);
    check("t6_ready", 32'(ld_ready), 1);
    send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b1);
    check("t6_run", 32'(run), 1);
    read_imem("t6_imem0", 5'd0, 12'hABC);
    read_imem("t6_imem1", 5'd1, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
